// File: rtl/fetch_sequencer.sv
// Two-state fetch/execute sequencer: owns the PC and IR, drives the instruction
// ROM address, and decodes the IR into one-cycle datapath strobes.
module fetch_sequencer #(
   parameter int WORD_W = 8,
   parameter int OP_W   = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [WORD_W-1:0]      Idata,
   input  logic                   z_flag,
   input  logic                   stall,
   output logic [WORD_W-OP_W-1:0] Iaddress,
   output logic [WORD_W-OP_W-1:0] Daddress,
   output logic                   op_load,
   output logic                   op_store,
   output logic                   op_add,
   output logic                   op_sub,
   output logic                   exec
);

   localparam int A_W = WORD_W - OP_W;

   localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);

   localparam logic [A_W-1:0] PC_ONE = A_W'(1);

   typedef enum logic {FETCH, EXEC} state_t;

   state_t              state;
   logic [A_W-1:0]      pc;
   logic [WORD_W-1:0]   ir;
   logic [OP_W-1:0]     opcode;
   logic [A_W-1:0]      operand;

   assign opcode  = ir[WORD_W-1 -: OP_W];
   assign operand = ir[A_W-1:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= FETCH;
         pc    <= '0;
         ir    <= '0;
      end else if (!stall) begin
         case (state)
            FETCH: begin
               ir    <= Idata;
               pc    <= pc + PC_ONE;
               state <= EXEC;
            end
            EXEC: begin
               // BNE is the only instruction that redirects the PC
               if (opcode == OP_BNE && !z_flag)
                  pc <= operand;
               state <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end

   // Strobes are gated by stall so a frozen EXEC never repeats a datapath action
   always_comb begin
      op_load  = 1'b0;
      op_store = 1'b0;
      op_add   = 1'b0;
      op_sub   = 1'b0;
      if (state == EXEC && !stall) begin
         case (opcode)
            OP_LOAD:  op_load  = 1'b1;
            OP_STORE: op_store = 1'b1;
            OP_ADD:   op_add   = 1'b1;
            OP_SUB:   op_sub   = 1'b1;
            default:  ;
         endcase
      end
   end

   assign exec     = (state == EXEC);
   assign Iaddress = pc;
   assign Daddress = operand;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Two-state fetch/execute sequencer for the basic 8-bit processor, sitting directly downstream of the instruction ROM. It owns the program counter, drives the ROM address, and latches the returned instruction word into an instruction register. It decodes the opcode into one-cycle control strobes for the datapath (accumulator, ALU, data memory) and resolves `BNE` branches from the ALU zero flag.

## Interface
- `WORD_W`, default 8: instruction and data word width.
- `OP_W`, default 3: opcode field width (MSBs of the instruction); the operand/address field is `WORD_W-OP_W` bits.
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high reset.
- `Idata`  in  WORD_W  instruction word from ROM, combinational from `Iaddress`.
- `z_flag`  in  1  registered ALU zero flag (result of last ADD/SUB was zero).
- `stall`  in  1  freezes the sequencer while high.
- `Iaddress`  out  WORD_W-OP_W  ROM address, equal to the PC register.
- `Daddress`  out  WORD_W-OP_W  operand field of the IR: data address or branch target.
- `op_load`  out  1  strobe: accumulator <= dmem[Daddress].
- `op_store`  out  1  strobe: dmem[Daddress] <= accumulator (data-memory write enable).
- `op_add`  out  1  strobe: accumulator <= accumulator + dmem[Daddress], Z updated.
- `op_sub`  out  1  strobe: accumulator <= accumulator - dmem[Daddress], Z updated.
- `exec`  out  1  high while in EXEC state (instruction being executed).

## Operation
- Opcode encodings come from `opcodes.svh`: LOAD=000, STORE=001, ADD=010, SUB=011, BNE=100. Codes 101–111 are executed as NOP: no strobe and no PC change beyond the normal increment.
- Registers:
  - PC, `WORD_W-OP_W` bits.
  - IR, `WORD_W` bits.
  - state ∈ {FETCH, EXEC}.
- FETCH, when `stall` is low:
  - IR <= `Idata`.
  - PC <= PC+1, modulo 2^(WORD_W-OP_W); 31 wraps to 0.
  - Next state is EXEC.
- EXEC, when `stall` is low:
  - Exactly one strobe asserts, selected by IR[WORD_W-1 -: OP_W]; none asserts for BNE or NOP.
  - For BNE, when `z_flag`=0: PC <= IR operand field.
  - Next state is FETCH.
- Strobes are combinational from state and IR. They are zero in FETCH and zero whenever `stall`=1. A strobe never lasts more than one non-stalled cycle per instruction.
- `Daddress` = IR[WORD_W-OP_W-1:0] at all times. `Iaddress` = PC at all times.
- `stall`=1: PC, IR and state hold, and all strobes are 0. Execution resumes exactly where it stopped.
- `reset`=1, checked at each rising edge and taking priority over `stall`:
  - PC=0, IR=0, state=FETCH.
  - After reset: `Iaddress`=0, `Daddress`=0, `exec`=0, all strobes 0.
  - A reset asserted mid-EXEC drops the pending strobe in that cycle. The cycle after reset is a FETCH from address 0.
- A branch target equal to the current PC is legal and produces a tight loop.

## Timing
- Two cycles per instruction when not stalled: FETCH, then EXEC.
- ROM access is combinational. `Idata` for PC is sampled at the end of the FETCH cycle.
- `z_flag` is sampled during EXEC. The datapath updates Z at the clock edge that ends an ADD/SUB EXEC cycle, so a BNE immediately after an ADD sees that ADD's result.
- Branch resolution: the FETCH following a taken BNE presents the target on `Iaddress` in its first cycle.
- No combinational path from `Idata` to any output. Only `z_flag` and `stall` reach outputs combinationally, and `z_flag` affects PC only.

## Test plan
- Reset and first fetch:
  - Hold `reset` for 2 cycles, then release.
  - `Iaddress`=0, all strobes 0, `exec`=0.
  - With `Idata`=8'b001_11110 (STORE 30): IR=8'h3E after the first edge, PC=1.
  - `op_store`=1 with `Daddress`=30 for exactly one cycle.
- Program STORE 30 / LOAD 30 / ADD 31 / STORE 30 / BNE 1 at addresses 0–4, `z_flag`=0:
  - Strobe sequence is store, load, add, store, then no strobe.
  - `Iaddress` returns to 1 at cycle 10.
- Same program with `z_flag`=1 during the BNE EXEC: not taken, `Iaddress`=5 on the next FETCH.
- Stall: raise `stall` for 3 cycles during the EXEC of ADD 31.
  - `op_add` stays 0 while stalled, and PC/IR are unchanged.
  - `op_add` pulses once in the first cycle after `stall` falls.
- Wrap and NOP:
  - Force PC to 31 with `Idata`=8'b101_00000: PC becomes 0 and no strobe fires in EXEC.
  - BNE 31 at address 31 with `z_flag`=0 loops at address 31.
- Reset mid-EXEC with `stall`=1 and STORE in IR: the strobe never asserts, and the next cycle has `Iaddress`=0 in FETCH.
